// File: rtl/beta_pc_ctl.sv
// Next-PC sequencing controller for the Beta fetch stage.
// Arbitrates redirects from decode, memory retry and the interrupt line,
// drives the fetch PC select / stall, squashes wrong-path instructions and
// halts the core on a supervisor-mode illegal instruction.
module beta_pc_ctl #(
    parameter int ANNUL_SLOTS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_stall,
    input  logic        mem_busy,
    input  logic        mem_retry,
    input  logic        op_illegal,
    input  logic        op_jmp,
    input  logic        op_br_taken,
    input  logic        supervisor,
    input  logic        irq,
    output logic [2:0]  pcsel,
    output logic        stall,
    output logic        annul,
    output logic        irq_ack,
    output logic        halted,
    output logic [15:0] trap_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ANNUL  = 2'd1,
        ST_REPLAY = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [2:0]  PC_NEXT   = 3'd0;
    localparam logic [2:0]  PC_BRANCH = 3'd1;
    localparam logic [2:0]  PC_JUMP   = 3'd2;
    localparam logic [2:0]  PC_ILLOP  = 3'd3;
    localparam logic [2:0]  PC_XADR   = 3'd4;
    localparam logic [2:0]  PC_MWAIT  = 3'd5;
    localparam logic [1:0]  SLOTS     = 2'(ANNUL_SLOTS);
    localparam logic [15:0] TRAP_MAX  = 16'hFFFF;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        irq_pending_reg, irq_pending_next;
    logic [15:0] trap_count_reg, trap_count_next;
    logic        trap_take;

    // State, annul counter, irq latch and trap counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            cnt_reg         <= 2'd0;
            irq_pending_reg <= 1'b0;
            trap_count_reg  <= 16'd0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            irq_pending_reg <= irq_pending_next;
            trap_count_reg  <= trap_count_next;
        end
    end

    // Next-state and output decode from the registered state plus live inputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pcsel      = PC_NEXT;
        stall      = 1'b0;
        annul      = 1'b0;
        irq_ack    = 1'b0;
        halted     = 1'b0;
        trap_take  = 1'b0;

        case (state_reg)
            ST_RUN: begin
                stall = hz_stall | mem_busy;
                if (!stall) begin
                    if (op_illegal && supervisor) begin
                        // Fault while already in kernel mode: no handler to go to.
                        state_next = ST_HALT;
                    end else if (op_illegal) begin
                        pcsel      = PC_ILLOP;
                        trap_take  = 1'b1;
                        state_next = ST_ANNUL;
                        cnt_next   = SLOTS;
                    end else if (irq_pending_reg && !supervisor) begin
                        pcsel      = PC_XADR;
                        irq_ack    = 1'b1;
                        trap_take  = 1'b1;
                        state_next = ST_ANNUL;
                        cnt_next   = SLOTS;
                    end else if (op_jmp) begin
                        pcsel      = PC_JUMP;
                        state_next = ST_ANNUL;
                        cnt_next   = SLOTS;
                    end else if (op_br_taken) begin
                        pcsel      = PC_BRANCH;
                        state_next = ST_ANNUL;
                        cnt_next   = SLOTS;
                    end
                end
            end
            ST_ANNUL: begin
                stall = hz_stall | mem_busy;
                annul = 1'b1;
                // Decode is on the wrong path here, so op_* are not looked at.
                if (!stall) begin
                    cnt_next = (cnt_reg == 2'd0) ? 2'd0 : cnt_reg - 2'd1;
                    if (cnt_reg <= 2'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_REPLAY: begin
                pcsel      = PC_MWAIT;
                annul      = 1'b1;
                state_next = ST_ANNUL;
                cnt_next   = SLOTS;
            end
            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // A memory retry pre-empts any redirect or stall decision this cycle.
        if (mem_retry && (state_reg != ST_HALT)) begin
            state_next = ST_REPLAY;
            cnt_next   = 2'd0;
            pcsel      = PC_NEXT;
            irq_ack    = 1'b0;
            trap_take  = 1'b0;
        end
    end

    // Interrupt latch and saturating trap counter updates.
    always_comb begin
        irq_pending_next = irq_ack ? 1'b0 : (irq_pending_reg | irq);
        trap_count_next  = trap_count_reg;
        if (trap_take && (trap_count_reg != TRAP_MAX)) begin
            trap_count_next = trap_count_reg + 16'd1;
        end
    end

    assign trap_count = trap_count_reg;

endmodule

// File: tb/tb_beta_pc_ctl.sv
// Scoreboard bench for beta_pc_ctl: a cycle-level reference model pushes the
// expected outputs for every driven cycle; a monitor pops and compares them.
module tb_beta_pc_ctl;

    localparam int SLOTS = 2;

    logic        clk = 1'b0;
    logic        reset, hz_stall, mem_busy, mem_retry;
    logic        op_illegal, op_jmp, op_br_taken, supervisor, irq;
    logic [2:0]  pcsel;
    logic        stall, annul, irq_ack, halted;
    logic [15:0] trap_count;

    beta_pc_ctl #(.ANNUL_SLOTS(SLOTS)) dut (
        .clk        (clk),
        .reset      (reset),
        .hz_stall   (hz_stall),
        .mem_busy   (mem_busy),
        .mem_retry  (mem_retry),
        .op_illegal (op_illegal),
        .op_jmp     (op_jmp),
        .op_br_taken(op_br_taken),
        .supervisor (supervisor),
        .irq        (irq),
        .pcsel      (pcsel),
        .stall      (stall),
        .annul      (annul),
        .irq_ack    (irq_ack),
        .halted     (halted),
        .trap_count (trap_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] id;
        logic [2:0]  pcsel;
        logic        stall;
        logic        annul;
        logic        irq_ack;
        logic        halted;
        logic [15:0] trap_count;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   txn_id = 0;

    // Reference model: remaining annul cycles, pending replay, dead core,
    // latched interrupt and trap tally kept as plain integers/flags.
    int m_annul_left;
    bit m_replay;
    bit m_dead;
    bit m_pending;
    int m_traps;

    function automatic void model_reset();
        m_annul_left = 0;
        m_replay     = 0;
        m_dead       = 0;
        m_pending    = 0;
        m_traps      = 0;
    endfunction

    function automatic void count_trap();
        if (m_traps < 65535) m_traps = m_traps + 1;
    endfunction

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] expv, int id);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s txn %0d: got %0d expected %0d", nm, id, act, expv);
        end
    endfunction

    // One driven clock cycle; frc preloads the trap counter near saturation.
    task automatic cyc(input bit rst, input bit hz, input bit mb, input bit rt,
                       input bit il, input bit jp, input bit br,
                       input bit sp, input bit iq, input bit frc = 1'b0);
        exp_t e;
        bit   taken;
        @(posedge clk);
        #1;
        if (frc) begin
            force dut.trap_count_reg = 16'hFFFD;
            #1;
            release dut.trap_count_reg;
            m_traps = 65533;
        end
        reset = rst; hz_stall = hz; mem_busy = mb; mem_retry = rt;
        op_illegal = il; op_jmp = jp; op_br_taken = br; supervisor = sp; irq = iq;
        if (rst) begin
            model_reset();
        end else begin
            taken        = 0;
            e.id         = txn_id;
            e.stall      = m_dead ? 1'b1 : (m_replay ? 1'b0 : (hz | mb));
            e.annul      = !m_dead && (m_replay || m_annul_left > 0);
            e.halted     = m_dead;
            e.pcsel      = 3'd0;
            e.irq_ack    = 1'b0;
            e.trap_count = 16'(m_traps);
            if (m_dead) begin
            end else if (rt) begin
                m_replay = 1; m_annul_left = 0;
            end else if (m_replay) begin
                e.pcsel = 3'd5; m_replay = 0; m_annul_left = SLOTS;
            end else if (e.stall) begin
            end else if (m_annul_left > 0) begin
                m_annul_left--;
            end else if (il && sp) begin
                m_dead = 1;
            end else if (il) begin
                e.pcsel = 3'd3; count_trap(); m_annul_left = SLOTS;
            end else if (m_pending && !sp) begin
                e.pcsel = 3'd4; e.irq_ack = 1'b1; taken = 1;
                count_trap(); m_annul_left = SLOTS;
            end else if (jp) begin
                e.pcsel = 3'd2; m_annul_left = SLOTS;
            end else if (br) begin
                e.pcsel = 3'd1; m_annul_left = SLOTS;
            end
            m_pending = taken ? 1'b0 : (m_pending | iq);
            exp_q.push_back(e);
            txn_id++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[TB] txn %0d pcsel=%0d stall=%0b annul=%0b ack=%0b halted=%0b traps=%0d",
                         e.id, pcsel, stall, annul, irq_ack, halted, trap_count);
                chk("pcsel",      16'(pcsel),   16'(e.pcsel),   e.id);
                chk("stall",      16'(stall),   16'(e.stall),   e.id);
                chk("annul",      16'(annul),   16'(e.annul),   e.id);
                chk("irq_ack",    16'(irq_ack), 16'(e.irq_ack), e.id);
                chk("halted",     16'(halted),  16'(e.halted),  e.id);
                chk("trap_count", trap_count,   e.trap_count,   e.id);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        bit rs, hz, mb, rt, il, jp, br, sp, iq;
        reset = 1'b1; hz_stall = 0; mem_busy = 0; mem_retry = 0;
        op_illegal = 0; op_jmp = 0; op_br_taken = 0; supervisor = 0; irq = 0;
        model_reset();

        // Reset then JMP.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(SLOTS + 2);

        // Illegal and irq together: ILLOP first, XADR after the annul window.
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1);
        idle(SLOTS + 4);

        // Branch held across three memory-busy cycles.
        for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(SLOTS + 1);

        // Retry while annulling a jump, plus irq with jmp in the same cycle.
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(SLOTS + 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(SLOTS + 2);

        // Retry together with an illegal opcode: no trap counted.
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(SLOTS + 3);

        // Interrupt masked in supervisor mode, taken once it clears.
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(SLOTS + 3);

        // Trap counter saturation.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
            idle(SLOTS);
        end

        // Double fault: halted persists, retry ignored, reset recovers.
        cyc(0, 0, 0, 0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, (k == 4), 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rs = ($urandom_range(0, 99) < 2);
            hz = ($urandom_range(0, 99) < 15);
            mb = ($urandom_range(0, 99) < 10);
            rt = ($urandom_range(0, 99) < 5);
            il = ($urandom_range(0, 99) < 6);
            jp = ($urandom_range(0, 99) < 20);
            br = ($urandom_range(0, 99) < 20);
            sp = ($urandom_range(0, 99) < 20);
            iq = ($urandom_range(0, 99) < 10);
            cyc(rs, hz, mb, rt, il, jp, br, sp, iq);
        end
        idle(1);

        @(posedge clk);
        @(posedge clk);
        chk("drain", 16'(exp_q.size()), 16'd0, txn_id);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
